bcd_convert_ctrl: RTL and testbench



---
 rtl/bcd_convert_ctrl.sv | 159 +++++++++++++++
 tb/tb_bcd_convert_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_convert_ctrl.sv
// Sequential binary-to-BCD converter (double dabble) with start/ready/done handshake.
// Optional overflow flag port `ovf` is enabled by defining BCD_OVF_FLAG_EN.
module bcd_convert_ctrl #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
`ifdef BCD_OVF_FLAG_EN
  output logic                  ovf,
`endif
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int DIG_W = 4 * DIGITS;
  localparam int SR_W  = DIG_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADJUST = 2'd1,
    S_SHIFT  = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // addOrNo cell: a digit of 5 or more gets 3 added so the next shift carries correctly.
  function automatic logic [3:0] add_or_no(input logic [3:0] a);
    logic [3:0] b;
    if (a >= 4'd5) begin
      b = a + 4'd3;
    end else begin
      b = a;
    end
    return b;
  endfunction

  state_e             state_q, state_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIG_W-1:0]   bcd_q, bcd_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DIG_W-1:0]   adj_s;
  logic [SR_W-1:0]    shift_s;
`ifdef BCD_OVF_FLAG_EN
  logic               ovf_acc_q, ovf_acc_d;
  logic               ovf_q, ovf_d;
`endif

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      assign adj_s[4*g +: 4] = add_or_no(sr_q[BIN_W + 4*g +: 4]);
    end
  endgenerate

  assign shift_s = {sr_q[SR_W-2:0], 1'b0};

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
`ifdef BCD_OVF_FLAG_EN
    ovf_acc_d = ovf_acc_q;
    ovf_d     = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d      = {{DIG_W{1'b0}}, bin_in};
          cnt_d     = CNT_W'(BIN_W);
          state_d   = S_ADJUST;
`ifdef BCD_OVF_FLAG_EN
          ovf_acc_d = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADJUST: begin
        sr_d    = {adj_s, sr_q[BIN_W-1:0]};
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        sr_d  = shift_s;
        cnt_d = cnt_q - CNT_W'(1);
`ifdef BCD_OVF_FLAG_EN
        ovf_acc_d = ovf_acc_q | sr_q[SR_W-1];
`endif
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = shift_s[SR_W-1:BIN_W];
          state_d = S_DONE;
`ifdef BCD_OVF_FLAG_EN
          ovf_d   = ovf_acc_q | sr_q[SR_W-1];
`endif
        end else begin
          state_d = S_ADJUST;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Handshake outputs are registered, so derive them from the upcoming state.
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d == S_ADJUST) || (state_d == S_SHIFT);
    done_d  = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sr_q      <= {SR_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      bcd_q     <= {DIG_W{1'b0}};
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef BCD_OVF_FLAG_EN
      ovf_acc_q <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef BCD_OVF_FLAG_EN
      ovf_acc_q <= ovf_acc_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
`ifdef BCD_OVF_FLAG_EN
  assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Self-checking bench for bcd_convert_ctrl: directed scenarios plus a shuffled
// sweep of every 8-bit input, checked against an arithmetic BCD model.
module tb_bcd_convert_ctrl;

  localparam int BIN_W = 8;
`ifdef BCD_OVF_FLAG_EN
  localparam int DIGITS = 2;
`else
  localparam int DIGITS = 3;
`endif
  localparam int DIG_W = 4 * DIGITS;
  localparam int LIM   = 10 ** DIGITS;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [BIN_W-1:0] bin_in = '0;
  logic             ready, busy, done;
  logic [DIG_W-1:0] bcd_out;
`ifdef BCD_OVF_FLAG_EN
  logic             ovf;
  logic             prev_ovf = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  logic [DIG_W-1:0] prev_bcd = '0;

  bcd_convert_ctrl #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .bin_in (bin_in),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
`ifdef BCD_OVF_FLAG_EN
    .ovf    (ovf),
`endif
    .bcd_out(bcd_out)
  );

  always #5 clk = ~clk;

  // Decimal digits by plain division, truncated to the available digit count.
  function automatic logic [DIG_W-1:0] ref_bcd(input int v);
    int r;
    logic [DIG_W-1:0] res;
    r = v % LIM;
    res = '0;
    for (int d = 0; d < DIGITS; d++) begin
      res[4*d +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return res;
  endfunction

  // Launch one conversion from a point where ready=1 and check it cycle by cycle.
  task automatic do_conv(input int v, input bit noise);
    logic [DIG_W-1:0] exp_b;
    exp_b = ref_bcd(v);
    start = 1'b1;
    bin_in = v[BIN_W-1:0];
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 2*BIN_W; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || ready !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL busy_phase v=%0d cyc=%0d got busy=%b ready=%b done=%b want 1 0 0", v, i, busy, ready, done);
      end
      checks++;
      if (bcd_out !== prev_bcd) begin
        failures++;
        $display("FAIL bcd_hold v=%0d cyc=%0d got %h want %h", v, i, bcd_out, prev_bcd);
      end
`ifdef BCD_OVF_FLAG_EN
      checks++;
      if (ovf !== prev_ovf) begin
        failures++;
        $display("FAIL ovf_hold v=%0d cyc=%0d got %b want %b", v, i, ovf, prev_ovf);
      end
`endif
      start = noise && (i == 2 || i == 8);
      if (noise) bin_in = 8'd200;
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || ready !== 1'b0) begin
      failures++;
      $display("FAIL done_cycle v=%0d got done=%b busy=%b ready=%b want 1 0 0", v, done, busy, ready);
    end
    checks++;
    if (bcd_out !== exp_b) begin
      failures++;
      $display("FAIL bcd_value v=%0d got %h want %h", v, bcd_out, exp_b);
    end
    prev_bcd = exp_b;
`ifdef BCD_OVF_FLAG_EN
    checks++;
    if (ovf !== (v >= LIM)) begin
      failures++;
      $display("FAIL ovf_value v=%0d got %b want %b", v, ovf, (v >= LIM));
    end
    prev_ovf = (v >= LIM);
`endif
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || bcd_out !== exp_b) begin
      failures++;
      $display("FAIL after_done v=%0d got ready=%b done=%b busy=%b bcd=%h want 1 0 0 %h", v, ready, done, busy, bcd_out, exp_b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || bcd_out !== '0) begin
      failures++;
      $display("FAIL reset_state got ready=%b busy=%b done=%b bcd=%h want 1 0 0 0", ready, busy, done, bcd_out);
    end
`ifdef BCD_OVF_FLAG_EN
    checks++;
    if (ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf got %b want 0", ovf);
    end
    prev_ovf = 1'b0;
`endif
    prev_bcd = '0;
  endtask

  task automatic test_back_to_back();
    do_conv(255, 1'b0);
    do_conv(0, 1'b0);
    do_conv(99, 1'b0);
    do_conv(100, 1'b0);
  endtask

  task automatic test_ignore_start();
    do_conv(37, 1'b1);
  endtask

  task automatic test_reset_mid();
    int done_seen;
    done_seen = 0;
    start = 1'b1;
    bin_in = 8'd128;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || bcd_out !== '0) begin
      failures++;
      $display("FAIL mid_reset got ready=%b busy=%b done=%b bcd=%h want 1 0 0 0", ready, busy, done, bcd_out);
    end
    for (int i = 0; i < 2*BIN_W + 2; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      failures++;
      $display("FAIL mid_reset_no_done got %0d pulses want 0", done_seen);
    end
    prev_bcd = '0;
`ifdef BCD_OVF_FLAG_EN
    prev_ovf = 1'b0;
`endif
    do_conv(128, 1'b0);
  endtask

  task automatic test_overflow();
    do_conv(200, 1'b0);
    do_conv(99, 1'b0);
  endtask

  task automatic test_sweep();
    int perm[256];
    int j, t;
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(2, 0)) begin
        bin_in = BIN_W'($urandom);
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
          failures++;
          $display("FAIL idle_gap got ready=%b done=%b want 1 0", ready, done);
        end
      end
      do_conv(perm[i], 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_overflow();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
